// File: rtl/pic_writer.sv
// Pixel writer for a 160x120x2 frame RAM: buffers plot requests in a 4-deep FIFO,
// drains them one per cycle, and can fill the whole frame with a single colour.
module pic_writer (
  input  logic        clk,
  input  logic        reset,
  input  logic        plot,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic [1:0]  colour,
  output logic        ready,
  input  logic        clear,
  input  logic [1:0]  clear_colour,
  output logic        busy,
  output logic        dropped,
  output logic [14:0] mem_address,
  output logic [1:0]  mem_data,
  output logic        mem_wren
);

  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_CLEAR} state_t;

  localparam logic [14:0] LAST_ADDR   = 15'd19199;
  localparam logic [17:0] FRAME_PIXELS = 18'd19200;

  state_t      r_state;
  state_t      w_state_next;

  logic [14:0] r_fifo_addr [4];
  logic [1:0]  r_fifo_col  [4];
  logic [1:0]  r_wr_ptr;
  logic [1:0]  r_rd_ptr;
  logic [2:0]  r_count;

  logic [14:0] r_fill_addr;
  logic [1:0]  r_clear_colour;
  logic        r_dropped;
  logic [14:0] r_mem_address;
  logic [1:0]  r_mem_data;
  logic        r_mem_wren;

  logic [17:0] w_addr_full;
  logic        w_in_range;
  logic        w_ready;
  logic        w_busy;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;
  logic        w_fill;
  logic        w_clear_accept;

  // Full 18-bit product so an out-of-range pixel can never alias into the frame.
  assign w_addr_full = 18'(y) * 18'd160 + 18'(x);
  assign w_in_range  = (x < 10'd160) && (y < 10'd120) && (w_addr_full < FRAME_PIXELS);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (clear) w_state_next = ST_DRAIN;
      ST_DRAIN: if (r_count == 3'd0) w_state_next = ST_CLEAR;
      ST_CLEAR: if (r_fill_addr == LAST_ADDR) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    w_ready        = (r_count < 3'd4) && (r_state == ST_IDLE) && !reset;
    w_busy         = (r_state != ST_IDLE);
    w_pop          = ((r_state == ST_IDLE) || (r_state == ST_DRAIN)) && (r_count != 3'd0);
    w_fill         = (r_state == ST_CLEAR);
    w_clear_accept = clear && (r_state == ST_IDLE);
    w_accept       = plot && w_ready;
    w_push         = w_accept && w_in_range;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_count  <= 3'd0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= w_addr_full[14:0];
      r_fifo_col[r_wr_ptr]  <= colour;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fill_addr    <= 15'd0;
      r_clear_colour <= 2'd0;
    end else begin
      if (w_clear_accept) begin
        r_clear_colour <= clear_colour;
        r_fill_addr    <= 15'd0;
      end else if (w_fill) begin
        r_fill_addr <= (r_fill_addr == LAST_ADDR) ? 15'd0 : r_fill_addr + 15'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem_address <= 15'd0;
      r_mem_data    <= 2'd0;
      r_mem_wren    <= 1'b0;
      r_dropped     <= 1'b0;
    end else begin
      r_dropped <= w_accept && !w_in_range;
      if (w_fill) begin
        r_mem_address <= r_fill_addr;
        r_mem_data    <= r_clear_colour;
        r_mem_wren    <= 1'b1;
      end else if (w_pop) begin
        r_mem_address <= r_fifo_addr[r_rd_ptr];
        r_mem_data    <= r_fifo_col[r_rd_ptr];
        r_mem_wren    <= 1'b1;
      end else begin
        r_mem_wren <= 1'b0;
      end
    end
  end

  assign ready       = w_ready;
  assign busy        = w_busy;
  assign dropped     = r_dropped;
  assign mem_address = r_mem_address;
  assign mem_data    = r_mem_data;
  assign mem_wren    = r_mem_wren;

endmodule

// File: tb/tb_pic_writer.sv
// Directed bench for pic_writer: vector table for single-pixel traffic, plus
// hand sequences for clear/fill, clear-while-busy and reset during a fill.
module tb_pic_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        plot;
  logic [9:0]  x;
  logic [9:0]  y;
  logic [1:0]  colour;
  logic        ready;
  logic        clear;
  logic [1:0]  clear_colour;
  logic        busy;
  logic        dropped;
  logic [14:0] mem_address;
  logic [1:0]  mem_data;
  logic        mem_wren;

  int n_cmp  = 0;
  int n_fail = 0;

  pic_writer dut (
    .clk          (clk),
    .reset        (reset),
    .plot         (plot),
    .x            (x),
    .y            (y),
    .colour       (colour),
    .ready        (ready),
    .clear        (clear),
    .clear_colour (clear_colour),
    .busy         (busy),
    .dropped      (dropped),
    .mem_address  (mem_address),
    .mem_data     (mem_data),
    .mem_wren     (mem_wren)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        plot;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [1:0]  col;
    logic        exp_ready;
    logic        exp_wren;
    logic [14:0] exp_addr;
    logic [1:0]  exp_data;
    logic        exp_dropped;
  } vec_t;

  localparam int NVEC = 22;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic p, input int vx, input int vy, input int vc,
                              input logic w, input int a, input int d, input logic dr);
    vec_t v;
    v.plot        = p;
    v.x           = 10'(vx);
    v.y           = 10'(vy);
    v.col         = 2'(vc);
    v.exp_ready   = 1'b1;
    v.exp_wren    = w;
    v.exp_addr    = 15'(a);
    v.exp_data    = 2'(d);
    v.exp_dropped = dr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int fill_next;
    int fill_bad;
    int extra;
    int guard;
    bit fill_started;
    bit pix_seen;
    bit done;

    // Rows: inputs for one cycle, outputs expected just after that cycle's edge.
    vecs[0]  = mk(1, 5, 2, 3,      0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0,      1, 325, 3, 0);
    vecs[2]  = mk(0, 0, 0, 0,      0, 0, 0, 0);
    vecs[3]  = mk(1, 160, 0, 1,    0, 0, 0, 1);
    vecs[4]  = mk(1, 0, 120, 2,    0, 0, 0, 1);
    vecs[5]  = mk(0, 0, 0, 0,      0, 0, 0, 0);
    vecs[6]  = mk(0, 0, 0, 0,      0, 0, 0, 0);
    vecs[7]  = mk(1, 10, 0, 0,     0, 0, 0, 0);
    vecs[8]  = mk(1, 11, 3, 1,     1, 10, 0, 0);
    vecs[9]  = mk(1, 12, 6, 2,     1, 491, 1, 0);
    vecs[10] = mk(1, 13, 9, 3,     1, 972, 2, 0);
    vecs[11] = mk(1, 14, 12, 0,    1, 1453, 3, 0);
    vecs[12] = mk(1, 15, 15, 1,    1, 1934, 0, 0);
    vecs[13] = mk(1, 16, 18, 2,    1, 2415, 1, 0);
    vecs[14] = mk(1, 17, 21, 3,    1, 2896, 2, 0);
    vecs[15] = mk(0, 0, 0, 0,      1, 3377, 3, 0);
    vecs[16] = mk(0, 0, 0, 0,      0, 0, 0, 0);
    vecs[17] = mk(1, 159, 119, 1,  0, 0, 0, 0);
    vecs[18] = mk(0, 0, 0, 0,      1, 19199, 1, 0);
    vecs[19] = mk(0, 0, 0, 0,      0, 0, 0, 0);
    vecs[20] = mk(1, 1023, 1023, 2, 0, 0, 0, 1);
    vecs[21] = mk(0, 0, 0, 0,      0, 0, 0, 0);

    reset = 1'b1; plot = 1'b0; x = '0; y = '0; colour = '0;
    clear = 1'b0; clear_colour = '0;

    repeat (2) step();
    chk("rst_wren", 32'(mem_wren), 0);
    chk("rst_addr", 32'(mem_address), 0);
    chk("rst_data", 32'(mem_data), 0);
    chk("rst_dropped", 32'(dropped), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready_in_reset", 32'(ready), 0);
    reset = 1'b0;
    #1;
    chk("rst_ready_after", 32'(ready), 1);
    $display("reset sequence done");

    for (int i = 0; i < NVEC; i++) begin
      plot = vecs[i].plot; x = vecs[i].x; y = vecs[i].y; colour = vecs[i].col;
      #1;
      chk($sformatf("v%0d_ready", i), 32'(ready), 32'(vecs[i].exp_ready));
      step();
      chk($sformatf("v%0d_wren", i), 32'(mem_wren), 32'(vecs[i].exp_wren));
      chk($sformatf("v%0d_dropped", i), 32'(dropped), 32'(vecs[i].exp_dropped));
      if (vecs[i].exp_wren) begin
        chk($sformatf("v%0d_addr", i), 32'(mem_address), 32'(vecs[i].exp_addr));
        chk($sformatf("v%0d_data", i), 32'(mem_data), 32'(vecs[i].exp_data));
      end
      $display("vec %0d: plot=%0d x=%0d y=%0d c=%0d -> wren=%0d addr=%0d data=%0d dropped=%0d",
               i, vecs[i].plot, vecs[i].x, vecs[i].y, vecs[i].col,
               mem_wren, mem_address, mem_data, dropped);
    end
    plot = 1'b0;

    // Plot and clear together, second clear mid-fill, blocked plot mid-fill.
    plot = 1'b1; x = 10'd1; y = 10'd1; colour = 2'd2;
    clear = 1'b1; clear_colour = 2'd1;
    #1;
    chk("pc_ready", 32'(ready), 1);
    step();
    plot = 1'b0; clear = 1'b0;
    chk("pc_busy", 32'(busy), 1);
    chk("pc_ready_busy", 32'(ready), 0);
    fill_next = 0; fill_bad = 0; fill_started = 0; pix_seen = 0; done = 0;
    x = 10'd3; y = 10'd0; colour = 2'd3; clear_colour = 2'd2;
    for (int cyc = 0; cyc < 19300 && !done; cyc++) begin
      clear = (fill_next == 100);
      plot  = (fill_next == 200);
      step();
      if (mem_wren) begin
        if (!fill_started && !pix_seen) begin
          chk("pc_pixel_addr", 32'(mem_address), 161);
          chk("pc_pixel_data", 32'(mem_data), 2);
          pix_seen = 1;
        end else begin
          fill_started = 1;
          if (mem_address !== 15'(fill_next) || mem_data !== 2'd1) fill_bad++;
          fill_next++;
          if (fill_next == 19200) begin
            done = 1;
            chk("pc_busy_after_fill", 32'(busy), 0);
          end
        end
      end else if (fill_started) begin
        fill_bad++;
      end
    end
    clear = 1'b0; plot = 1'b0;
    chk("pc_pixel_seen", 32'(pix_seen), 1);
    chk("pc_fill_done", 32'(done), 1);
    chk("pc_fill_count", 32'(fill_next), 19200);
    chk("pc_fill_bad", 32'(fill_bad), 0);
    extra = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      step();
      if (mem_wren) extra++;
    end
    chk("pc_post_fill_writes", 32'(extra), 0);
    chk("pc_ready_after", 32'(ready), 1);
    $display("clear with pixel: fill writes=%0d bad=%0d extra=%0d", fill_next, fill_bad, extra);

    // Clear on empty FIFO, then reset at fill address 5000.
    clear = 1'b1; clear_colour = 2'd3;
    step();
    clear = 1'b0;
    chk("ce_wren_drain", 32'(mem_wren), 0);
    chk("ce_busy", 32'(busy), 1);
    step();
    chk("ce_wren_drain2", 32'(mem_wren), 0);
    step();
    chk("ce_first_wren", 32'(mem_wren), 1);
    chk("ce_first_addr", 32'(mem_address), 0);
    chk("ce_first_data", 32'(mem_data), 3);
    guard = 0;
    while (!(mem_wren && mem_address == 15'd5000) && guard < 6000) begin
      step();
      guard++;
    end
    chk("ce_reached_5000", 32'(mem_wren && mem_address == 15'd5000), 1);
    reset = 1'b1;
    step();
    chk("ar_wren", 32'(mem_wren), 0);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_addr", 32'(mem_address), 0);
    reset = 1'b0;
    #1;
    chk("ar_ready", 32'(ready), 1);
    step();
    chk("ar_wren_idle", 32'(mem_wren), 0);
    plot = 1'b1; x = 10'd2; y = 10'd0; colour = 2'd1;
    #1;
    chk("ar_plot_ready", 32'(ready), 1);
    step();
    plot = 1'b0;
    step();
    chk("ar_plot_wren", 32'(mem_wren), 1);
    chk("ar_plot_addr", 32'(mem_address), 2);
    chk("ar_plot_data", 32'(mem_data), 1);
    $display("reset during fill: waited %0d cycles, plot after reset addr=%0d", guard, mem_address);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
